// File: rtl/cdma_arbiter.sv
// Two-requester round-robin arbiter that owns a single CDMA engine: latches one descriptor,
// issues a start pulse, waits for completion and reports done. Optional watchdog: CDMA_ARB_TIMEOUT_EN.
module cdma_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int CUBE_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int DESC_W        = 2 * ADDR_WIDTH + 5 * CUBE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DESC_W-1:0]     req0_desc,
  output logic                  req0_ready,
  output logic                  req0_done,
  input  logic                  req1_valid,
  input  logic [DESC_W-1:0]     req1_desc,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [ADDR_WIDTH-1:0] cdma_src_base_addr,
  output logic [ADDR_WIDTH-1:0] cdma_dst_base_addr,
  output logic [CUBE_WIDTH-1:0] cdma_channel,
  output logic [CUBE_WIDTH-1:0] cdma_row,
  output logic [CUBE_WIDTH-1:0] cdma_col,
  output logic [CUBE_WIDTH-1:0] cdma_channel_offset,
  output logic [CUBE_WIDTH-1:0] cdma_row_offset,
  output logic                  cdma_transfer_start,
  input  logic                  cdma_transfer_done,
  output logic                  busy,
  output logic                  grant_id,
  output logic                  timeout_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Descriptor field offsets, LSB first.
  localparam int DST_LO  = ADDR_WIDTH;
  localparam int CH_LO   = 2 * ADDR_WIDTH;
  localparam int ROW_LO  = CH_LO + CUBE_WIDTH;
  localparam int COL_LO  = ROW_LO + CUBE_WIDTH;
  localparam int CHO_LO  = COL_LO + CUBE_WIDTH;
  localparam int ROWO_LO = CHO_LO + CUBE_WIDTH;

  logic [1:0]        state;
  logic              any_valid;
  logic              sel;
  logic [DESC_W-1:0] sel_desc;
  logic              zero_size;

  // The requester that did not win last time has priority when both are pending.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    sel       = (req0_valid && req1_valid) ? ~grant_id : req1_valid;
    sel_desc  = sel ? req1_desc : req0_desc;
    zero_size = (sel_desc[CH_LO  +: CUBE_WIDTH] == '0) ||
                (sel_desc[ROW_LO +: CUBE_WIDTH] == '0) ||
                (sel_desc[COL_LO +: CUBE_WIDTH] == '0);
  end

  assign req0_ready          = (state == IDLE) && any_valid && !sel;
  assign req1_ready          = (state == IDLE) && any_valid &&  sel;
  assign req0_done           = (state == DONE) && !grant_id;
  assign req1_done           = (state == DONE) &&  grant_id;
  assign cdma_transfer_start = (state == ISSUE);
  assign busy                = (state != IDLE);

`ifdef CDMA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_q;
  assign timeout_err = timeout_q;
`else
  // Parameter is kept so both builds share one interface; the flag is constant 0.
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // NOTE: all state updates below use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      grant_id            <= 1'b1;
      cdma_src_base_addr  <= '0;
      cdma_dst_base_addr  <= '0;
      cdma_channel        <= '0;
      cdma_row            <= '0;
      cdma_col            <= '0;
      cdma_channel_offset <= '0;
      cdma_row_offset     <= '0;
`ifdef CDMA_ARB_TIMEOUT_EN
      wait_cnt            <= '0;
      timeout_q           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id            <= sel;
            cdma_src_base_addr  <= sel_desc[0       +: ADDR_WIDTH];
            cdma_dst_base_addr  <= sel_desc[DST_LO  +: ADDR_WIDTH];
            cdma_channel        <= sel_desc[CH_LO   +: CUBE_WIDTH];
            cdma_row            <= sel_desc[ROW_LO  +: CUBE_WIDTH];
            cdma_col            <= sel_desc[COL_LO  +: CUBE_WIDTH];
            cdma_channel_offset <= sel_desc[CHO_LO  +: CUBE_WIDTH];
            cdma_row_offset     <= sel_desc[ROWO_LO +: CUBE_WIDTH];
            state               <= zero_size ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef CDMA_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (cdma_transfer_done) begin
            state <= DONE;
`ifdef CDMA_ARB_TIMEOUT_EN
          end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdma_arbiter.sv
// Directed self-checking bench for cdma_arbiter; define CDMA_ARB_TIMEOUT_EN to exercise the watchdog.
module tb_cdma_arbiter;

  localparam int AW = 32;
  localparam int CW = 6;
  localparam int DW = 2 * AW + 5 * CW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_desc = '0, req1_desc = '0;
  logic          req0_ready, req1_ready, req0_done, req1_done;
  logic [AW-1:0] cdma_src_base_addr, cdma_dst_base_addr;
  logic [CW-1:0] cdma_channel, cdma_row, cdma_col, cdma_channel_offset, cdma_row_offset;
  logic          cdma_transfer_start;
  logic          cdma_transfer_done = 1'b0;
  logic          busy, grant_id, timeout_err;

  int checks = 0;
  int fails  = 0;
  int start_cnt = 0;

  cdma_arbiter #(.ADDR_WIDTH(AW), .CUBE_WIDTH(CW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_desc(req0_desc), .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_desc(req1_desc), .req1_ready(req1_ready), .req1_done(req1_done),
    .cdma_src_base_addr(cdma_src_base_addr), .cdma_dst_base_addr(cdma_dst_base_addr),
    .cdma_channel(cdma_channel), .cdma_row(cdma_row), .cdma_col(cdma_col),
    .cdma_channel_offset(cdma_channel_offset), .cdma_row_offset(cdma_row_offset),
    .cdma_transfer_start(cdma_transfer_start), .cdma_transfer_done(cdma_transfer_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cdma_transfer_start) start_cnt++;

  function automatic logic [DW-1:0] mk_desc(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                            input logic [CW-1:0] ch, input logic [CW-1:0] row,
                                            input logic [CW-1:0] col, input logic [CW-1:0] cho,
                                            input logic [CW-1:0] rowo);
    return {rowo, cho, col, row, ch, dst, src};
  endfunction

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({req0_ready, req1_ready, req0_done, req1_done, cdma_transfer_start, busy, timeout_err} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000000",
        {req0_ready, req1_ready, req0_done, req1_done, cdma_transfer_start, busy, timeout_err});
    end
    checks++;
    if (grant_id !== 1'b1) begin fails++; $display("FAIL reset_grant: got %b want 1", grant_id); end
    checks++;
    if ({cdma_src_base_addr, cdma_dst_base_addr, cdma_channel, cdma_row, cdma_col,
         cdma_channel_offset, cdma_row_offset} !== '0) begin
      fails++; $display("FAIL reset_cdma_regs: src %h dst %h not all zero", cdma_src_base_addr, cdma_dst_base_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int bad;
    req0_desc  = mk_desc(32'h1000, 32'h2000, 6'd2, 6'd4, 6'd6, 6'd8, 6'd2);
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      fails++; $display("FAIL single_ready: got r0 %b r1 %b busy %b want 1 0 0", req0_ready, req1_ready, busy);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({cdma_transfer_start, grant_id, busy, req0_ready} !== 4'b1010) begin
      fails++; $display("FAIL single_start: got start %b grant %b busy %b ready %b want 1 0 1 0",
        cdma_transfer_start, grant_id, busy, req0_ready);
    end
    checks++;
    if (cdma_src_base_addr !== 32'h1000 || cdma_dst_base_addr !== 32'h2000 || cdma_channel !== 6'd2 ||
        cdma_row !== 6'd4 || cdma_col !== 6'd6 || cdma_channel_offset !== 6'd8 || cdma_row_offset !== 6'd2) begin
      fails++; $display("FAIL single_regs: got %h %h %0d %0d %0d %0d %0d want 1000 2000 2 4 6 8 2",
        cdma_src_base_addr, cdma_dst_base_addr, cdma_channel, cdma_row, cdma_col,
        cdma_channel_offset, cdma_row_offset);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cdma_transfer_start || !busy || req0_done || req1_done) bad++;
    end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL single_wait: got %0d bad cycles want 0", bad); end
    cdma_transfer_done = 1'b1;
    tick();
    cdma_transfer_done = 1'b0;
    checks++;
    if ({req0_done, req1_done} !== 2'b10) begin
      fails++; $display("FAIL single_done: got d0 %b d1 %b want 1 0", req0_done, req1_done);
    end
    tick();
    checks++;
    if ({req0_done, busy, cdma_src_base_addr} !== {2'b00, 32'h1000}) begin
      fails++; $display("FAIL single_after: got done %b busy %b src %h want 0 0 1000", req0_done, busy, cdma_src_base_addr);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int starts0;
    logic exp;
    test_reset();
    req0_desc  = mk_desc(32'hA000, 32'hB000, 6'd1, 6'd1, 6'd1, 6'd0, 6'd0);
    req1_desc  = mk_desc(32'hC000, 32'hD000, 6'd3, 6'd3, 6'd3, 6'd1, 6'd1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    starts0    = start_cnt;
    for (int t = 0; t < 4; t++) begin
      exp = logic'(t % 2);
      n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 10) begin tick(); n++; end
      checks++;
      if ({req0_ready, req1_ready} !== {~exp, exp}) begin
        fails++; $display("FAIL rr_ready_%0d: got r0 %b r1 %b want grant %0d", t, req0_ready, req1_ready, exp);
      end
      tick();
      checks++;
      if (cdma_transfer_start !== 1'b1 || grant_id !== exp ||
          cdma_src_base_addr !== (exp ? 32'hC000 : 32'hA000)) begin
        fails++; $display("FAIL rr_issue_%0d: got start %b grant %b src %h want 1 %b", t,
          cdma_transfer_start, grant_id, cdma_src_base_addr, exp);
      end
      repeat (3) tick();
      cdma_transfer_done = 1'b1;
      tick();
      cdma_transfer_done = 1'b0;
      checks++;
      if ({req0_done, req1_done} !== {~exp, exp}) begin
        fails++; $display("FAIL rr_done_%0d: got d0 %b d1 %b want grant %0d", t, req0_done, req1_done, exp);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (start_cnt - starts0 !== 4) begin
      fails++; $display("FAIL rr_start_count: got %0d want 4", start_cnt - starts0);
    end
    repeat (2) tick();
  endtask

  task automatic test_zero_size();
    int starts0;
    starts0    = start_cnt;
    req1_desc  = mk_desc(32'h3000, 32'h4000, 6'd5, 6'd5, 6'd0, 6'd1, 6'd1);
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      fails++; $display("FAIL zero_ready: got r0 %b r1 %b want 0 1", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    checks++;
    if ({cdma_transfer_start, req1_done, req0_done, busy, grant_id} !== 5'b01011) begin
      fails++; $display("FAIL zero_done: got start %b d1 %b d0 %b busy %b grant %b want 0 1 0 1 1",
        cdma_transfer_start, req1_done, req0_done, busy, grant_id);
    end
    tick();
    checks++;
    if ({req1_done, busy, cdma_col} !== {2'b00, 6'd0} || start_cnt !== starts0) begin
      fails++; $display("FAIL zero_after: got d1 %b busy %b col %0d starts %0d want 0 0 0 %0d",
        req1_done, busy, cdma_col, start_cnt, starts0);
    end
  endtask

  task automatic test_spurious_done();
    cdma_transfer_done = 1'b1;
    tick();
    cdma_transfer_done = 1'b0;
    checks++;
    if ({req0_done, req1_done, busy} !== 3'b000) begin
      fails++; $display("FAIL spur_idle: got d0 %b d1 %b busy %b want 0 0 0", req0_done, req1_done, busy);
    end
    req0_desc  = mk_desc(32'h5000, 32'h6000, 6'd1, 6'd2, 6'd3, 6'd0, 6'd0);
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    cdma_transfer_done = 1'b1;
    checks++;
    if (cdma_transfer_start !== 1'b1) begin fails++; $display("FAIL spur_issue: got start %b want 1", cdma_transfer_start); end
    tick();
    cdma_transfer_done = 1'b0;
    checks++;
    if ({req0_done, req1_done, busy, cdma_transfer_start} !== 4'b0010) begin
      fails++; $display("FAIL spur_wait: got d0 %b d1 %b busy %b start %b want 0 0 1 0",
        req0_done, req1_done, busy, cdma_transfer_start);
    end
    tick();
    checks++;
    if ({req0_done, busy} !== 2'b01) begin fails++; $display("FAIL spur_hold: got d0 %b busy %b want 0 1", req0_done, busy); end
    cdma_transfer_done = 1'b1;
    tick();
    cdma_transfer_done = 1'b0;
    checks++;
    if (req0_done !== 1'b1) begin fails++; $display("FAIL spur_real_done: got %b want 1", req0_done); end
    tick();
  endtask

  task automatic test_reset_mid();
    req1_desc  = mk_desc(32'h7000, 32'h8000, 6'd2, 6'd2, 6'd2, 6'd2, 6'd2);
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({req0_done, req1_done, busy, cdma_transfer_start, grant_id, cdma_src_base_addr, cdma_channel} !==
        {5'b00001, 32'h0, 6'd0}) begin
      fails++; $display("FAIL midrst_state: got d0 %b d1 %b busy %b start %b grant %b src %h want 0 0 0 0 1 0",
        req0_done, req1_done, busy, cdma_transfer_start, grant_id, cdma_src_base_addr);
    end
    cdma_transfer_done = 1'b1;
    tick();
    cdma_transfer_done = 1'b0;
    checks++;
    if ({req0_done, req1_done, busy} !== 3'b000) begin
      fails++; $display("FAIL midrst_late_done: got d0 %b d1 %b busy %b want 0 0 0", req0_done, req1_done, busy);
    end
    tick();
    checks++;
    if ({req0_done, req1_done, busy} !== 3'b000) begin
      fails++; $display("FAIL midrst_after: got d0 %b d1 %b busy %b want 0 0 0", req0_done, req1_done, busy);
    end
  endtask

  task automatic test_timeout();
    req0_desc  = mk_desc(32'h9000, 32'h9100, 6'd1, 6'd1, 6'd1, 6'd0, 6'd0);
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
`ifdef CDMA_ARB_TIMEOUT_EN
    repeat (15) tick();
    checks++;
    if ({timeout_err, req0_done, busy} !== 3'b001) begin
      fails++; $display("FAIL tmo_early: got err %b d0 %b busy %b want 0 0 1", timeout_err, req0_done, busy);
    end
    tick();
    checks++;
    if ({timeout_err, req0_done, req1_done} !== 3'b110) begin
      fails++; $display("FAIL tmo_fire: got err %b d0 %b d1 %b want 1 1 0", timeout_err, req0_done, req1_done);
    end
    repeat (3) tick();
    checks++;
    if ({timeout_err, req0_done, busy} !== 3'b100) begin
      fails++; $display("FAIL tmo_sticky: got err %b d0 %b busy %b want 1 0 0", timeout_err, req0_done, busy);
    end
`else
    repeat (40) tick();
    checks++;
    if ({timeout_err, req0_done, busy} !== 3'b001) begin
      fails++; $display("FAIL tmo_disabled: got err %b d0 %b busy %b want 0 0 1", timeout_err, req0_done, busy);
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({timeout_err, busy} !== 2'b00) begin
      fails++; $display("FAIL tmo_reset: got err %b busy %b want 0 0", timeout_err, busy);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_size();
    test_spurious_done();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
